br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
//  Tracks in-flight branch predictions between lookup and resolution and feeds
//  the 2-bit counter FSM (fin_sta_mac) with its update: torn = actual direction,
//  upd_data = counter state read at predict time. Also owns the speculative
//  global history register (GHR) used upstream for table indexing, with repair
//  on mispredict. Sits between the predictor lookup and fin_sta_mac.
// PARAMETERS
//  DEPTH    8   max in-flight predictions (power of 2, >=2)
//  IDX_W    10  counter-table index width
//  GHR_W    8   global history length (>=2)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  pred_valid   in   1      new prediction issued
//  pred_idx     in   IDX_W  counter-table index used for the lookup
//  pred_state   in   2      counter state read; predicted dir = pred_state[1]
//  pred_ready   out  1      queue can accept a prediction (= !full)
//  res_valid    in   1      oldest branch resolved
//  res_taken    in   1      actual direction
//  res_ready    out  1      queue non-empty (= !empty)
//  flush        in   1      pipeline flush: discard all entries
//  ghr_out      out  GHR_W  current speculative history
//  upd_valid    out  1      update strobe to fin_sta_mac
//  upd_idx      out  IDX_W  index to write back
//  upd_data     out  2      stored counter state (fin_sta_mac in_data)
//  torn         out  1      actual direction (fin_sta_mac torn)
//  mispredict   out  1      res_taken != stored predicted dir
// BEHAVIOUR
//  - Circular FIFO: wr_ptr, rd_ptr, count (0..DEPTH). Entry = {idx, state, snap}
//    where snap = GHR value before this prediction's shift.
//  - push = pred_valid & pred_ready; pop = res_valid & res_ready. res_valid on
//    empty queue and pred_valid on full queue are ignored (no state change).
//  - Push+pop same cycle allowed, incl. at full (pred_ready is still !full, so
//    push blocked at full) and at count==1 (entry popped, new one stored).
//  - Push: GHR <= {GHR[GHR_W-2:0], pred_state[1]}.
//  - Pop: registered outputs next cycle (latency 1): upd_valid=1, upd_idx,
//    upd_data = head entry fields, torn = res_taken,
//    mispredict = res_taken ^ state[1]. upd_valid is a single-cycle pulse.
//  - Mispredict on pop: queue cleared (count=0, ptrs=0), any same-cycle push
//    dropped, GHR <= {snap[GHR_W-2:0], res_taken}. Overrides push GHR shift.
//  - flush: queue cleared, GHR unchanged, same-cycle push dropped. A same-cycle
//    pop still produces its update; if it mispredicts, GHR repair still applies.
//  - No-pop cycle: upd_valid=0, mispredict=0; upd_idx/upd_data/torn hold.
//  - Reset (priority over all): count=0, ptrs=0, GHR=0, upd_valid=0, upd_idx=0,
//    upd_data=2'b00, torn=0, mispredict=0; pred_ready=1, res_ready=0.
//    Reset mid-operation discards all entries with no update emitted.
//  - Pointer wrap at DEPTH-1 -> 0; count never exceeds DEPTH or drops below 0.
// TESTING
//  1 Reset, then idle -> pred_ready=1, res_ready=0, ghr_out=0, upd_valid=0.
//  2 Push idx=5 st=2'b11; pop res_taken=1 -> next cycle upd_valid=1, upd_idx=5,
//    upd_data=2'b11, torn=1, mispredict=0; ghr_out=8'h01.
//  3 Push 8 entries (DEPTH=8) -> pred_ready=0; 9th push ignored; pop+push same
//    cycle at full blocked push, count=7; push again -> ptr wraps, order kept.
//  4 Push A(st=01, GHR 0->0), B(st=11, GHR->01), C; pop A res_taken=1 ->
//    mispredict=1, count=0, ghr_out=8'h01 (snap 0 shifted with 1).
//  5 Flush with 3 entries and simultaneous pop -> one update emitted, count=0,
//    pred_ready=1, res_ready=0; GHR unchanged if pop predicted correctly.
//  6 Reset asserted with 4 entries pending -> no upd_valid, all outputs at
//    reset values next cycle.

Source files
------------

// File: rtl/br_resolve_queue_if.sv
// Handshake bundle between the predictor lookup, the branch resolution stage and
// the counter-update path of br_resolve_queue.
interface br_resolve_queue_if #(
    parameter int IDX_W = 10,
    parameter int GHR_W = 8
);
    logic             pred_valid;
    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       pred_state;
    logic             pred_ready;

    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             flush;

    logic [GHR_W-1:0] ghr_out;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_data;
    logic             torn;
    logic             mispredict;

    // Pipeline side: issues predictions/resolutions, consumes updates and history.
    modport master (
        output pred_valid, pred_idx, pred_state, res_valid, res_taken, flush,
        input  pred_ready, res_ready, ghr_out, upd_valid, upd_idx, upd_data,
               torn, mispredict
    );

    // Queue side.
    modport slave (
        input  pred_valid, pred_idx, pred_state, res_valid, res_taken, flush,
        output pred_ready, res_ready, ghr_out, upd_valid, upd_idx, upd_data,
               torn, mispredict
    );
endinterface

// File: rtl/br_resolve_queue.sv
// In-order queue of in-flight branch predictions: emits counter updates on
// resolution and maintains the speculative global history with mispredict repair.
module br_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 10,
    parameter int GHR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    br_resolve_queue_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Only the low GHR_W-1 history bits survive a repair shift, so the MSB is not stored.
    logic [IDX_W-1:0] idx_mem  [DEPTH];
    logic [1:0]       st_mem   [DEPTH];
    logic [GHR_W-2:0] snap_mem [DEPTH];

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic [1:0]       upd_data_q, upd_data_d;
    logic             torn_q, torn_d;
    logic             mispredict_q, mispredict_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic             mis;
    logic             clear;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       head_st;
    logic [GHR_W-2:0] head_snap;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign head_idx  = idx_mem[rd_q];
    assign head_st   = st_mem[rd_q];
    assign head_snap = snap_mem[rd_q];

    always_comb begin
        push    = bus.pred_valid & ~full;
        pop     = bus.res_valid & ~empty;
        mis     = pop & (bus.res_taken ^ head_st[1]);
        clear   = bus.flush | mis;
        push_ok = push & ~clear;

        wr_d         = wr_q;
        rd_d         = rd_q;
        count_d      = count_q;
        ghr_d        = ghr_q;
        upd_valid_d  = pop;
        mispredict_d = mis;
        upd_idx_d    = upd_idx_q;
        upd_data_d   = upd_data_q;
        torn_d       = torn_q;

        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Repair rebuilds history as if the resolved branch had been predicted correctly.
        if (mis) begin
            ghr_d = {head_snap, bus.res_taken};
        end else if (push_ok) begin
            ghr_d = {ghr_q[GHR_W-2:0], bus.pred_state[1]};
        end

        if (pop) begin
            upd_idx_d  = head_idx;
            upd_data_d = head_st;
            torn_d     = bus.res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            ghr_q        <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_data_q   <= 2'b00;
            torn_q       <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            ghr_q        <= ghr_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_data_q   <= upd_data_d;
            torn_q       <= torn_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Entry storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            idx_mem[wr_q]  <= bus.pred_idx;
            st_mem[wr_q]   <= bus.pred_state;
            snap_mem[wr_q] <= ghr_q[GHR_W-2:0];
        end
    end

    assign bus.pred_ready = ~full;
    assign bus.res_ready  = ~empty;
    assign bus.ghr_out    = ghr_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.upd_data   = upd_data_q;
    assign bus.torn       = torn_q;
    assign bus.mispredict = mispredict_q;
endmodule

// File: tb/tb_br_resolve_queue.sv
// Randomized scoreboard bench for br_resolve_queue against a queue-based
// behavioural model of prediction tracking and history repair.
module tb_br_resolve_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 10;
    localparam int GHR_W = 8;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       st;
        logic [GHR_W-1:0] snap;
    } ent_t;

    typedef struct {
        int               cyc;
        logic [IDX_W-1:0] idx;
        logic [1:0]       st;
        logic             torn;
        logic             mis;
    } upd_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    ent_t             model_q[$];
    logic [GHR_W-1:0] model_ghr;
    upd_t             sb[$];

    br_resolve_queue_if #(.IDX_W(IDX_W), .GHR_W(GHR_W)) bus ();

    br_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus, entered and left on a falling edge.
    task automatic cycle(input bit pv, input logic [IDX_W-1:0] idx, input logic [1:0] st,
                         input bit rv, input bit rt, input bit fl, input bit rs);
        ent_t h;
        bit   push;
        bit   pop;
        bit   mis;
        upd_t u;
        chk("pred_ready", bus.pred_ready, model_q.size() < DEPTH);
        chk("res_ready", bus.res_ready, model_q.size() > 0);
        chk("ghr_out", bus.ghr_out, model_ghr);

        bus.pred_valid = pv;
        bus.pred_idx   = idx;
        bus.pred_state = st;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        bus.flush      = fl;
        reset          = rs;

        if (rs) begin
            model_q.delete();
            model_ghr = '0;
        end else begin
            push = pv && (model_q.size() < DEPTH);
            pop  = rv && (model_q.size() > 0);
            mis  = 1'b0;
            if (pop) begin
                h      = model_q.pop_front();
                mis    = (rt != h.st[1]);
                u.cyc  = cyc + 1;
                u.idx  = h.idx;
                u.st   = h.st;
                u.torn = rt;
                u.mis  = mis;
                sb.push_back(u);
            end
            if (fl || mis) begin
                model_q.delete();
                if (mis) model_ghr = {h.snap[GHR_W-2:0], rt};
            end else if (push) begin
                h.idx  = idx;
                h.st   = st;
                h.snap = model_ghr;
                model_q.push_back(h);
                model_ghr = {model_ghr[GHR_W-2:0], st[1]};
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, '0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic do_push(input logic [IDX_W-1:0] idx, input logic [1:0] st);
        cycle(1, idx, st, 0, 0, 0, 0);
    endtask

    function automatic bit head_dir();
        return (model_q.size() > 0) ? model_q[0].st[1] : 1'b0;
    endfunction

    // Monitor: pops the scoreboard whenever an update is due and checks hold behaviour otherwise.
    initial begin
        logic             rs;
        bit               due;
        upd_t             e;
        logic [IDX_W-1:0] last_idx;
        logic [1:0]       last_st;
        logic             last_torn;
        last_idx  = '0;
        last_st   = '0;
        last_torn = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            rs = reset;
            #1;
            if (rs) begin
                chk("rst_upd_valid", bus.upd_valid, 0);
                chk("rst_upd_idx", bus.upd_idx, 0);
                chk("rst_upd_data", bus.upd_data, 0);
                chk("rst_torn", bus.torn, 0);
                chk("rst_mispredict", bus.mispredict, 0);
                last_idx  = '0;
                last_st   = '0;
                last_torn = 1'b0;
            end else begin
                due = (sb.size() > 0) && (sb[0].cyc == cyc);
                chk("upd_valid", bus.upd_valid, due);
                if (due) begin
                    e = sb.pop_front();
                    chk("upd_idx", bus.upd_idx, e.idx);
                    chk("upd_data", bus.upd_data, e.st);
                    chk("torn", bus.torn, e.torn);
                    chk("mispredict", bus.mispredict, e.mis);
                    last_idx  = e.idx;
                    last_st   = e.st;
                    last_torn = e.torn;
                end else begin
                    chk("idle_mispredict", bus.mispredict, 0);
                    chk("hold_upd_idx", bus.upd_idx, last_idx);
                    chk("hold_upd_data", bus.upd_data, last_st);
                    chk("hold_torn", bus.torn, last_torn);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_ghr = '0;
        bus.pred_valid = 0;
        bus.pred_idx   = '0;
        bus.pred_state = '0;
        bus.res_valid  = 0;
        bus.res_taken  = 0;
        bus.flush      = 0;
        reset          = 1;
        repeat (2) @(negedge clk);
        reset = 0;

        // Idle after reset
        idle();
        chk("t1_ghr", bus.ghr_out, 8'h00);
        chk("t1_pred_ready", bus.pred_ready, 1);
        chk("t1_res_ready", bus.res_ready, 0);

        // Single correct prediction
        do_push(10'd5, 2'b11);
        cycle(0, '0, 2'b00, 1, 1, 0, 0);
        idle();
        chk("t2_ghr", bus.ghr_out, 8'h01);

        // Fill, overflow attempt, pop+push at full, wrap
        cycle(0, '0, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) do_push(IDX_W'(16 + i), 2'b11);
        chk("t3_full", bus.pred_ready, 0);
        do_push(10'h3ff, 2'b00);
        cycle(1, 10'h2aa, 2'b10, 1, head_dir(), 0, 0);
        chk("t3_after_popfull", bus.pred_ready, 1);
        do_push(10'h155, 2'b10);
        chk("t3_full_again", bus.pred_ready, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 2'b00, 1, head_dir(), 0, 0);
        chk("t3_empty", bus.res_ready, 0);

        // Mispredict repair
        cycle(0, '0, 2'b00, 0, 0, 0, 1);
        do_push(10'd1, 2'b01);
        do_push(10'd2, 2'b11);
        do_push(10'd3, 2'b10);
        cycle(0, '0, 2'b00, 1, 1, 0, 0);
        chk("t4_ghr", bus.ghr_out, 8'h01);
        chk("t4_res_ready", bus.res_ready, 0);

        // Flush with simultaneous correct pop
        cycle(0, '0, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) do_push(IDX_W'(40 + i), 2'b11);
        cycle(1, 10'd99, 2'b11, 1, 1, 1, 0);
        chk("t5_ghr", bus.ghr_out, 8'h07);
        chk("t5_pred_ready", bus.pred_ready, 1);
        chk("t5_res_ready", bus.res_ready, 0);

        // Reset with pending entries
        for (int i = 0; i < 4; i++) do_push(IDX_W'(60 + i), 2'b10);
        cycle(0, '0, 2'b00, 1, 1, 0, 1);
        idle();
        chk("t6_ghr", bus.ghr_out, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit pv;
            bit rv;
            bit rt;
            bit fl;
            bit rs;
            pv = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 5);
            rt = ($urandom_range(0, 9) < 8) ? head_dir() : 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(pv, IDX_W'($urandom), 2'($urandom), rv, rt, fl, rs);
        end

        repeat (3) idle();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
